// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU-control pipeline stage:
//   - 5-bit base ALU operation codes (zero-extended by users to CTRL_W)
//   - prefix that marks an RV32M multiply/divide code {1,0,funct3}
//   - ALUOp main-decoder class encodings
//   - FSM state enum for the multiply/divide sequencer
//   - small constant helpers for sizing the latency counter
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;

    // Upper two bits of an M-extension code; the low three bits are funct3.
    localparam logic [1:0] MDU_PREFIX = 2'b10;

    // ALUOp classes; any value with bit 1 set is an R/I-type instruction.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold n-1 without wrapping; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aluctl_decode.sv
// -----------------------------------------------------------------------------
// aluctl_decode
// Purely combinational ALU-control decoder.
// Ports:
//   ALUOp     [1:0]  main-decoder class (00 add, 01 branch, 1x R/I-type)
//   funct3    [2:0]  instruction funct3 field
//   opb5             opcode bit 5 (1 = register-register form)
//   funct7b5         funct7 bit 5 (sub / sra select)
//   funct7b0         funct7 bit 0 (RV32M select)
//   ctrl_code [CTRL_W-1:0]  decoded ALU operation, zero-extended
//   is_mdu           decoded operation is a multiply/divide
// -----------------------------------------------------------------------------
module aluctl_decode
    import alu_pkg::*;
#(
    parameter int CTRL_W   = 5,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic              opb5,
    input  logic              funct7b5,
    input  logic              funct7b0,
    output logic [CTRL_W-1:0] ctrl_code,
    output logic              is_mdu
);

    logic [4:0] base_s;
    logic       mdu_s;

    // Select the 5-bit operation code from the instruction class and fields.
    always_comb begin
        base_s = ALU_ADD;
        mdu_s  = 1'b0;
        case (ALUOp)
            ALUOP_ADD: begin
                base_s = ALU_ADD;
            end
            ALUOP_BRANCH: begin
                // beq/bne compare by subtraction; blt/bge and bltu/bgeu use set-less-than.
                case (funct3[2:1])
                    2'b10:   base_s = ALU_SLT;
                    2'b11:   base_s = ALU_SLTU;
                    default: base_s = ALU_SUB;
                endcase
            end
            default: begin
                if (ENABLE_M && opb5 && funct7b0) begin
                    base_s = {MDU_PREFIX, funct3};
                    mdu_s  = 1'b1;
                end else begin
                    case (funct3)
                        // addi never subtracts, so sub needs the register form too.
                        3'b000:  base_s = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                        3'b001:  base_s = ALU_SLL;
                        3'b010:  base_s = ALU_SLT;
                        3'b011:  base_s = ALU_SLTU;
                        3'b100:  base_s = ALU_XOR;
                        3'b101:  base_s = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  base_s = ALU_OR;
                        3'b111:  base_s = ALU_AND;
                        default: base_s = ALU_ADD;
                    endcase
                end
            end
        endcase
    end

    assign ctrl_code = CTRL_W'(base_s);
    assign is_mdu    = mdu_s;

endmodule

// File: rtl/aluctl_pipe.sv
// -----------------------------------------------------------------------------
// aluctl_pipe
// EX-stage ALU-control register with a multiply/divide sequencer.
// An instruction is accepted when valid_i=1, stall_o=0 and flush_i=0; its
// decoded code appears on ALUControl one cycle later. M-extension ops hold the
// stage BUSY for MUL_CYCLES (funct3[2]=0) or DIV_CYCLES (funct3[2]=1) cycles.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   valid_i, flush_i  decode-stage valid, EX-stage/M-unit kill
//   ALUOp, funct3, opb5, funct7b5, funct7b0   decode inputs
//   ALUControl        registered operation code
//   valid_o           ALUControl holds a live instruction
//   mdu_start_o       pulse in the first BUSY cycle
//   mdu_done_o        pulse in the final BUSY cycle
//   mdu_kill_o        pulse when a running M op is flushed
//   stall_o           upstream hold request
// -----------------------------------------------------------------------------
module aluctl_pipe
    import alu_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic              opb5,
    input  logic              funct7b5,
    input  logic              funct7b0,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              valid_o,
    output logic              mdu_start_o,
    output logic              mdu_done_o,
    output logic              mdu_kill_o,
    output logic              stall_o
);

    localparam int CNT_W = cnt_width(max_int(MUL_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 32'sd1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              start_r;
    logic              start_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic [CTRL_W-1:0] ctrl_r;
    logic [CTRL_W-1:0] ctrl_nxt_s;

    logic [CTRL_W-1:0] dec_code_s;
    logic              dec_is_mdu_s;
    logic              busy_s;
    logic              cnt_zero_s;
    logic              stall_s;
    logic              done_s;
    logic              accept_s;

    aluctl_decode #(
        .CTRL_W   (CTRL_W),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .opb5      (opb5),
        .funct7b5  (funct7b5),
        .funct7b0  (funct7b0),
        .ctrl_code (dec_code_s),
        .is_mdu    (dec_is_mdu_s)
    );

    assign busy_s     = (state_r == ST_BUSY);
    assign cnt_zero_s = (count_r == {CNT_W{1'b0}});
    // The last BUSY cycle does not stall, so a new instruction can follow at once.
    assign stall_s    = busy_s & ~cnt_zero_s;
    assign done_s     = busy_s & cnt_zero_s;
    assign accept_s   = valid_i & ~stall_s & ~flush_i;

    // Next-state, counter and EX-register computation; flush wins over everything.
    always_comb begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = {CNT_W{1'b0}};
        start_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        ctrl_nxt_s  = ctrl_r;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else if (accept_s) begin
            valid_nxt_s = 1'b1;
            ctrl_nxt_s  = dec_code_s;
            if (dec_is_mdu_s) begin
                state_nxt_s = ST_BUSY;
                start_nxt_s = 1'b1;
                count_nxt_s = funct3[2] ? DIV_LOAD : MUL_LOAD;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (stall_s) begin
            // Still running: keep the M instruction live and count down.
            state_nxt_s = ST_BUSY;
            count_nxt_s = count_r - CNT_W'(1);
            valid_nxt_s = valid_r;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // State and EX-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
            start_r <= 1'b0;
            valid_r <= 1'b0;
            ctrl_r  <= {CTRL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            start_r <= start_nxt_s;
            valid_r <= valid_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign ALUControl  = ctrl_r;
    assign valid_o     = valid_r;
    assign mdu_start_o = start_r;
    assign mdu_done_o  = done_s;
    // Kill must hit the M unit in the flush cycle itself; reset aborts silently.
    assign mdu_kill_o  = stall_s & flush_i & ~reset;
    assign stall_o     = stall_s;

endmodule

// File: tb/tb_aluctl_pipe.sv
// -----------------------------------------------------------------------------
// tb_aluctl_pipe
// Two instances share the same stimulus: dut_a (M enabled, MUL=1, DIV=4) and
// dut_b (M disabled). A transaction-level model tracks, per instance, the live
// EX instruction and the position k (1..N) inside a running M operation.
// -----------------------------------------------------------------------------
module tb_aluctl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic       flush_i;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic       opb5;
    logic       funct7b5;
    logic       funct7b0;

    wire [1:0][4:0] ctl;
    wire [1:0]      vo;
    wire [1:0]      st;
    wire [1:0]      dn;
    wire [1:0]      kl;
    wire [1:0]      sl;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int P_EN  [2] = '{1, 0};
    int P_MUL [2] = '{1, 2};
    int P_DIV [2] = '{4, 3};

    int m_valid [2] = '{0, 0};
    int m_code  [2] = '{0, 0};
    int m_len   [2] = '{0, 0};
    int m_k     [2] = '{0, 0};

    always #5 clk = ~clk;

    aluctl_pipe #(.CTRL_W(5), .ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .funct3(funct3), .opb5(opb5), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .ALUControl(ctl[0]), .valid_o(vo[0]), .mdu_start_o(st[0]), .mdu_done_o(dn[0]),
        .mdu_kill_o(kl[0]), .stall_o(sl[0])
    );

    aluctl_pipe #(.CTRL_W(5), .ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .funct3(funct3), .opb5(opb5), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .ALUControl(ctl[1]), .valid_o(vo[1]), .mdu_start_o(st[1]), .mdu_done_o(dn[1]),
        .mdu_kill_o(kl[1]), .stall_o(sl[1])
    );

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Operation code written directly from the decode table.
    function automatic int ref_code(input int en);
        if (ALUOp == 2'b00) return 0;
        if (ALUOp == 2'b01) begin
            if (funct3[2:1] == 2'b10) return 2;
            if (funct3[2:1] == 2'b11) return 3;
            return 8;
        end
        if (en != 0 && opb5 && funct7b0) return 16 + int'(funct3);
        case (funct3)
            3'd0:    return (funct7b5 && opb5) ? 8 : 0;
            3'd5:    return funct7b5 ? 13 : 5;
            default: return int'(funct3);
        endcase
    endfunction

    function automatic bit ref_is_m(input int en);
        return (en != 0) && ALUOp[1] && opb5 && funct7b0;
    endfunction

    function automatic bit m_stall(input int i);
        return (m_len[i] != 0) && (m_k[i] < m_len[i]);
    endfunction

    // Model update on the clock edge, from the inputs the DUTs sample.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_valid[i] <= 0; m_code[i] <= 0; m_len[i] <= 0; m_k[i] <= 0;
            end else if (flush_i) begin
                m_valid[i] <= 0; m_len[i] <= 0; m_k[i] <= 0;
            end else if (valid_i && !m_stall(i)) begin
                m_valid[i] <= 1;
                m_code[i]  <= ref_code(P_EN[i]);
                if (ref_is_m(P_EN[i])) begin
                    m_len[i] <= funct3[2] ? P_DIV[i] : P_MUL[i];
                    m_k[i]   <= 1;
                end else begin
                    m_len[i] <= 0; m_k[i] <= 0;
                end
            end else if (m_stall(i)) begin
                m_k[i] <= m_k[i] + 1;
            end else begin
                m_valid[i] <= 0; m_len[i] <= 0; m_k[i] <= 0;
            end
        end
        if (reset) chk_en <= 1'b1;
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit busy;
                busy = (m_len[i] != 0);
                check("valid_o", i, 32'(vo[i]), 32'(m_valid[i]));
                check("ALUControl", i, 32'(ctl[i]), 32'(m_code[i]));
                check("stall_o", i, 32'(sl[i]), 32'(busy && m_k[i] < m_len[i]));
                check("mdu_start_o", i, 32'(st[i]), 32'(busy && m_k[i] == 1));
                check("mdu_done_o", i, 32'(dn[i]), 32'(busy && m_k[i] == m_len[i]));
                check("mdu_kill_o", i, 32'(kl[i]),
                      32'(busy && m_k[i] < m_len[i] && flush_i && !reset));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reset = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        ALUOp = 2'b00; funct3 = 3'b000; opb5 = 1'b0; funct7b5 = 1'b0; funct7b0 = 1'b0;
    endtask

    task automatic instr(input logic [1:0] op, input logic [2:0] f3,
                         input logic o5, input logic f75, input logic f70);
        valid_i = 1'b1; ALUOp = op; funct3 = f3; opb5 = o5; funct7b5 = f75; funct7b0 = f70;
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        @(posedge clk);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 0, 32'(vo[0]), 32'd0);
        check("rst_ctl", 0, 32'(ctl[0]), 32'd0);
        check("rst_stall", 0, 32'(sl[0]), 32'd0);

        // sub, register form
        cyc(); instr(2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        @(negedge clk); check("sub_nostall", 0, 32'(sl[0]), 32'd0);
        cyc(); idle_in();
        @(negedge clk);
        check("sub_code", 0, 32'(ctl[0]), 32'h08);
        check("sub_valid", 0, 32'(vo[0]), 32'd1);

        // div with DIV_CYCLES=4, add back-to-back in the done cycle
        cyc(); instr(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        cyc(); idle_in();
        @(negedge clk);
        check("div_start", 0, 32'(st[0]), 32'd1);
        check("div_stall1", 0, 32'(sl[0]), 32'd1);
        check("div_code", 0, 32'(ctl[0]), 32'h14);
        cyc(); @(negedge clk); check("div_stall2", 0, 32'(sl[0]), 32'd1);
        cyc(); @(negedge clk); check("div_stall3", 0, 32'(sl[0]), 32'd1);
        cyc(); instr(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("div_done", 0, 32'(dn[0]), 32'd1);
        check("div_done_nostall", 0, 32'(sl[0]), 32'd0);
        cyc(); idle_in();
        @(negedge clk);
        check("b2b_valid", 0, 32'(vo[0]), 32'd1);
        check("b2b_code", 0, 32'(ctl[0]), 32'h00);

        // single-cycle multiply
        cyc(); instr(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
        cyc(); idle_in();
        @(negedge clk);
        check("mul_start", 0, 32'(st[0]), 32'd1);
        check("mul_done", 0, 32'(dn[0]), 32'd1);
        check("mul_nostall", 0, 32'(sl[0]), 32'd0);
        check("mul_code", 0, 32'(ctl[0]), 32'h10);

        // flush in the second BUSY cycle of a divide
        cyc(); instr(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
        cyc(); idle_in();
        cyc(); flush_i = 1'b1;
        @(negedge clk);
        check("flush_kill", 0, 32'(kl[0]), 32'd1);
        check("flush_nodone", 0, 32'(dn[0]), 32'd0);
        cyc(); idle_in();
        @(negedge clk);
        check("flush_valid", 0, 32'(vo[0]), 32'd0);
        check("flush_nodone2", 0, 32'(dn[0]), 32'd0);

        // M disabled: funct7b0 ignored
        cyc(); instr(2'b10, 3'b111, 1'b1, 1'b0, 1'b1);
        cyc(); idle_in();
        @(negedge clk);
        check("nom_code", 1, 32'(ctl[1]), 32'h07);
        check("m_code", 0, 32'(ctl[0]), 32'h17);
        repeat (4) cyc();

        // reset in the middle of BUSY, with flush and valid also high
        instr(2'b10, 3'b110, 1'b1, 1'b0, 1'b1);
        cyc(); idle_in();
        cyc(); reset = 1'b1; flush_i = 1'b1; instr(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_nokill", 0, 32'(kl[0]), 32'd0);
        cyc(); idle_in();
        @(negedge clk);
        check("rstb_ctl", 0, 32'(ctl[0]), 32'd0);
        check("rstb_valid", 0, 32'(vo[0]), 32'd0);
        check("rstb_start", 0, 32'(st[0]), 32'd0);
        check("rstb_done", 0, 32'(dn[0]), 32'd0);
        check("rstb_stall", 0, 32'(sl[0]), 32'd0);

        // randomized traffic, checked by the model
        repeat (3000) begin
            cyc();
            reset    = ($urandom_range(0, 63) == 0);
            flush_i  = ($urandom_range(0, 11) == 0);
            valid_i  = ($urandom_range(0, 3) != 0);
            ALUOp    = 2'($urandom_range(0, 3));
            funct3   = 3'($urandom_range(0, 7));
            opb5     = 1'($urandom_range(0, 1));
            funct7b5 = 1'($urandom_range(0, 1));
            funct7b0 = 1'($urandom_range(0, 1));
        end
        cyc(); idle_in();
        repeat (6) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
